// File: rtl/gpio_in_pkg.sv
// Shared types and constants for the GPIO input conditioner.
package gpio_in_pkg;

  localparam int unsigned SysClkFreq     = 30_000_000;
  // One debounce tick per millisecond at the default system clock.
  localparam int unsigned DefaultTickDiv = SysClkFreq / 1000;

  typedef struct packed {
    logic rise_en;
    logic fall_en;
  } gpio_in_cfg_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gpio_in_debounce_chan.sv
// One input channel: polarity fix, synchroniser, tick-based debounce and edge pulses.
module gpio_in_debounce_chan
  import gpio_in_pkg::*;
#(
  parameter int unsigned SyncStages    = 2,
  parameter int unsigned DebounceTicks = 10,
  parameter logic        Invert        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = cnt_width(DebounceTicks + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceTicks - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  s;
  logic                  level_r;
  logic                  level_q;
  logic [CntW-1:0]       cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pin ^ Invert};
    end
  end

  assign s = sync_q[SyncStages-1];

  // Any return to the accepted level restarts the window, so bounces never accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_r <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      level_q <= level_r;
      if (s == level_r) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CntLast) begin
          level_r <= ~level_r;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CntW'(1);
        end
      end
    end
  end

  assign level = level_r;
  assign rise  = level_r & ~level_q;
  assign fall  = ~level_r & level_q;

endmodule

// File: rtl/gpio_in_filter.sv
// Input conditioner top: shared debounce tick, per-channel filters, sticky maskable interrupts.
module gpio_in_filter
  import gpio_in_pkg::*;
#(
  parameter int unsigned      Width         = 16,
  parameter int unsigned      SyncStages    = 2,
  parameter int unsigned      TickDiv       = DefaultTickDiv,
  parameter int unsigned      DebounceTicks = 10,
  parameter logic [Width-1:0] InvertMask    = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] pins_i,
  output logic [Width-1:0] level_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  input  logic [Width-1:0] irq_rise_en_i,
  input  logic [Width-1:0] irq_fall_en_i,
  input  logic [Width-1:0] irq_clr_i,
  output logic [Width-1:0] irq_status_o,
  output logic             irq_o
);

  localparam int unsigned TickW = cnt_width(TickDiv);

  logic tick;

  // Free-running prescaler; input activity never realigns it.
  if (TickDiv == 1) begin : g_no_div
    assign tick = 1'b1;
  end else begin : g_div
    logic [TickW-1:0] tick_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        tick_cnt <= '0;
      end else if (tick_cnt == TickW'(TickDiv - 1)) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + TickW'(1);
      end
    end

    assign tick = (tick_cnt == TickW'(TickDiv - 1));
  end

  for (genvar i = 0; i < Width; i++) begin : g_chan
    gpio_in_debounce_chan #(
      .SyncStages   (SyncStages),
      .DebounceTicks(DebounceTicks),
      .Invert       (InvertMask[i])
    ) u_chan (
      .clk  (clk_i),
      .rst  (rst_i),
      .pin  (pins_i[i]),
      .tick (tick),
      .level(level_o[i]),
      .rise (rise_o[i]),
      .fall (fall_o[i])
    );
  end

  gpio_in_cfg_t [Width-1:0] cfg;
  logic [Width-1:0]         irq_set;
  logic [Width-1:0]         status_next;

  always_comb begin
    cfg     = '0;
    irq_set = '0;
    for (int i = 0; i < Width; i++) begin
      cfg[i].rise_en = irq_rise_en_i[i];
      cfg[i].fall_en = irq_fall_en_i[i];
      irq_set[i]     = (rise_o[i] & cfg[i].rise_en) | (fall_o[i] & cfg[i].fall_en);
    end
  end

  // A new event in the same cycle as a clear keeps the bit set.
  assign status_next = (irq_status_o & ~irq_clr_i) | irq_set;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_status_o <= '0;
      irq_o        <= 1'b0;
    end else begin
      irq_status_o <= status_next;
      irq_o        <= |status_next;
    end
  end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench: unprescaled instance (a) for edge/irq timing, prescaled instance (b) for tick alignment.
module tb_gpio_in_filter;

  logic        clk;
  logic        rst;
  logic [15:0] pins_a, rise_en_a, fall_en_a, clr_a;
  logic [15:0] level_a, rise_a, fall_a, status_a;
  logic        irq_a;
  logic [15:0] pins_b, rise_en_b, fall_en_b, clr_b;
  logic [15:0] level_b, rise_b, fall_b, status_b;
  logic        irq_b;

  int checks = 0;
  int errors = 0;

  gpio_in_filter #(
    .Width(16), .SyncStages(2), .TickDiv(1), .DebounceTicks(4), .InvertMask(16'hFFFF)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .pins_i(pins_a), .level_o(level_a), .rise_o(rise_a),
    .fall_o(fall_a), .irq_rise_en_i(rise_en_a), .irq_fall_en_i(fall_en_a),
    .irq_clr_i(clr_a), .irq_status_o(status_a), .irq_o(irq_a)
  );

  gpio_in_filter #(
    .Width(16), .SyncStages(2), .TickDiv(8), .DebounceTicks(3), .InvertMask(16'hFFFF)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .pins_i(pins_b), .level_o(level_b), .rise_o(rise_b),
    .fall_o(fall_b), .irq_rise_en_i(rise_en_b), .irq_fall_en_i(fall_en_b),
    .irq_clr_i(clr_b), .irq_status_o(status_b), .irq_o(irq_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pins_a = 16'hFFFF; pins_b = 16'hFFFF;
    rise_en_a = 16'h0008; fall_en_a = 16'h0008; clr_a = '0;
    rise_en_b = '0; fall_en_b = '0; clr_b = '0;
    step(3);
    checks++;
    if ({level_a, rise_a, fall_a, status_a, irq_a} !== '0) begin
      errors++;
      $display("FAIL reset_a lvl=%h rise=%h fall=%h st=%h irq=%b exp all 0",
               level_a, rise_a, fall_a, status_a, irq_a);
    end
    checks++;
    if ({level_b, rise_b, fall_b, status_b, irq_b} !== '0) begin
      errors++;
      $display("FAIL reset_b lvl=%h st=%h irq=%b exp all 0", level_b, status_b, irq_b);
    end
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step(1);
      checks++;
      if (level_a !== 16'h0 || irq_a !== 1'b0 || level_b !== 16'h0 || irq_b !== 1'b0) begin
        errors++;
        $display("FAIL idle c=%0d lvl_a=%h irq_a=%b lvl_b=%h irq_b=%b exp 0",
                 c, level_a, irq_a, level_b, irq_b);
      end
    end
  endtask

  task automatic test_clean_press();
    pins_a[3] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      checks++;
      if (e < 6 && (level_a[3] !== 1'b0 || rise_a[3] !== 1'b0 || status_a[3] !== 1'b0)) begin
        errors++;
        $display("FAIL press_early e=%0d lvl=%b rise=%b st=%b exp 0 0 0",
                 e, level_a[3], rise_a[3], status_a[3]);
      end
      if (e == 6 && (level_a[3] !== 1'b1 || rise_a[3] !== 1'b1 || status_a[3] !== 1'b0)) begin
        errors++;
        $display("FAIL press_edge6 lvl=%b rise=%b st=%b exp 1 1 0",
                 level_a[3], rise_a[3], status_a[3]);
      end
      if (e == 7 && (status_a[3] !== 1'b1 || irq_a !== 1'b1 || rise_a[3] !== 1'b0)) begin
        errors++;
        $display("FAIL press_edge7 st=%b irq=%b rise=%b exp 1 1 0",
                 status_a[3], irq_a, rise_a[3]);
      end
    end
  endtask

  task automatic test_bounce();
    int edges;
    int edge_at;
    edges = 0;
    edge_at = -1;
    for (int t = 0; t < 20; t++) begin
      pins_a[3] = ~pins_a[3];
      for (int k = 0; k < 2; k++) begin
        step(1);
        checks++;
        if (rise_a[3] !== 1'b0 || fall_a[3] !== 1'b0) begin
          errors++;
          $display("FAIL bounce_edge t=%0d rise=%b fall=%b exp 0 0", t, rise_a[3], fall_a[3]);
        end
      end
    end
    pins_a[3] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step(1);
      if (rise_a[3] === 1'b1 || fall_a[3] === 1'b1) begin
        edges++;
        edge_at = e;
      end
    end
    checks++;
    if (edges != 1 || edge_at != 6 || level_a[3] !== 1'b0) begin
      errors++;
      $display("FAIL settle edges=%0d at=%0d lvl=%b exp 1 at 6 lvl 0", edges, edge_at, level_a[3]);
    end
  endtask

  task automatic test_set_clear_collision();
    clr_a = 16'h0008;
    step(1);
    clr_a = '0;
    checks++;
    if (status_a[3] !== 1'b0 || irq_a !== 1'b0) begin
      errors++;
      $display("FAIL first_clear st=%b irq=%b exp 0 0", status_a[3], irq_a);
    end
    pins_a[3] = 1'b0;
    step(6);
    checks++;
    if (rise_a[3] !== 1'b1) begin
      errors++;
      $display("FAIL collide_rise rise=%b exp 1", rise_a[3]);
    end
    clr_a = 16'h0008;
    step(1);
    clr_a = '0;
    checks++;
    if (status_a[3] !== 1'b1 || irq_a !== 1'b1) begin
      errors++;
      $display("FAIL collide_set_wins st=%b irq=%b exp 1 1", status_a[3], irq_a);
    end
    step(2);
    clr_a = 16'h0008;
    step(1);
    clr_a = '0;
    checks++;
    if (status_a[3] !== 1'b0 || irq_a !== 1'b0) begin
      errors++;
      $display("FAIL lone_clear st=%b irq=%b exp 0 0", status_a[3], irq_a);
    end
  endtask

  task automatic test_prescaled();
    int reported;
    int lat;
    logic rise_seen;
    reported = 0;
    pins_b[0] = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step(1);
      if (level_b[0] === 1'b1 || rise_b[0] === 1'b1) reported++;
    end
    pins_b[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (level_b[0] === 1'b1 || rise_b[0] === 1'b1) reported++;
    end
    checks++;
    if (reported != 0) begin
      errors++;
      $display("FAIL short_pulse reported_cycles=%0d exp 0", reported);
    end
    lat = 0;
    rise_seen = 1'b0;
    pins_b[0] = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      step(1);
      if (lat == 0 && level_b[0] === 1'b1) begin
        lat = e;
        rise_seen = rise_b[0];
      end
    end
    checks++;
    if (lat < 18 || lat > 26) begin
      errors++;
      $display("FAIL prescale_latency got=%0d exp in [18,26]", lat);
    end
    checks++;
    if (rise_seen !== 1'b1) begin
      errors++;
      $display("FAIL prescale_rise got=%b exp 1", rise_seen);
    end
  endtask

  task automatic test_reset_mid_count();
    pins_a[3] = 1'b1;
    pins_a[0] = 1'b0;
    step(10);
    checks++;
    if (level_a !== 16'h0001 || status_a !== 16'h0008 || irq_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset lvl=%h st=%h irq=%b exp 0001 0008 1", level_a, status_a, irq_a);
    end
    pins_a[3] = 1'b0;
    step(4);
    rst = 1'b1;
    #1;
    checks++;
    if ({level_a, rise_a, fall_a, status_a, irq_a, level_b} !== '0) begin
      errors++;
      $display("FAIL async_reset lvl=%h rise=%h fall=%h st=%h irq=%b lvl_b=%h exp all 0",
               level_a, rise_a, fall_a, status_a, irq_a, level_b);
    end
    step(2);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      step(1);
      checks++;
      if (e < 6 && level_a !== 16'h0000) begin
        errors++;
        $display("FAIL post_reset_early e=%0d lvl=%h exp 0000", e, level_a);
      end
      if (e == 6 && (level_a !== 16'h0009 || rise_a !== 16'h0009)) begin
        errors++;
        $display("FAIL post_reset_edge6 lvl=%h rise=%h exp 0009 0009", level_a, rise_a);
      end
      if (e == 7 && (status_a !== 16'h0008 || irq_a !== 1'b1 || rise_a !== 16'h0)) begin
        errors++;
        $display("FAIL post_reset_edge7 st=%h irq=%b rise=%h exp 0008 1 0000",
                 status_a, irq_a, rise_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_set_clear_collision();
    test_prescaled();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
